// File: rtl/tracker_pkg.sv
// Shared tracker NoC flit formats, record layout and drain FSM encoding.
package tracker_pkg;

  localparam int COORD_W = 4;
  localparam int ADDR_W  = 8;

  typedef enum logic [1:0] {
    REQ_META  = 2'd0,
    REQ_ENTRY = 2'd1
  } req_type_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_META_REQ  = 3'd1,
    ST_META_RESP = 3'd2,
    ST_ENT_REQ   = 3'd3,
    ST_ENT_RESP  = 3'd4,
    ST_REC_OUT   = 3'd5,
    ST_DONE      = 3'd6
  } drain_state_e;

  typedef struct packed {
    logic [15:0] hits;
    logic [7:0]  tag;
    logic [7:0]  way;
  } tracker_stats_struct;

  localparam int TRACKER_STATS_W = $bits(tracker_stats_struct);

  typedef struct packed {
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] src_y;
    req_type_e          rtype;
    logic [ADDR_W-1:0]  addr;
  } req_flit_t;

  localparam int REQ_FLIT_W = $bits(req_flit_t);

  // Metadata responses use wrapped/wr_addr, entry responses use stats.
  typedef struct packed {
    logic                wrapped;
    logic [ADDR_W-1:0]   wr_addr;
    tracker_stats_struct stats;
  } resp_flit_t;

  localparam int RESP_FLIT_W = $bits(resp_flit_t);

  function automatic req_flit_t make_req(input int dx, input int dy, input int sx, input int sy,
                                         input req_type_e t, input logic [ADDR_W-1:0] a);
    req_flit_t f;
    f.dst_x = COORD_W'(dx);
    f.dst_y = COORD_W'(dy);
    f.src_x = COORD_W'(sx);
    f.src_y = COORD_W'(sy);
    f.rtype = t;
    f.addr  = a;
    return f;
  endfunction

endpackage

// File: rtl/tracker_log_drain_ctrl.sv
// Drain sequencing FSM: owns every valid/ready flag and strobes the datapath.
module tracker_log_drain_ctrl
  import tracker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_val_i,
  output logic start_rdy_o,
  output logic drain_req_val_o,
  input  logic drain_req_rdy_i,
  input  logic drain_resp_val_i,
  output logic drain_resp_rdy_o,
  output logic rec_val_o,
  input  logic rec_rdy_i,
  output logic done_val_o,
  output logic busy_o,
  input  logic meta_zero_i,
  input  logic rec_last_i,
  output logic meta_cap_o,
  output logic ent_cap_o,
  output logic rec_adv_o,
  output logic ld_meta_req_o,
  output logic ld_ent_req_o,
  output logic ld_done_o
);

  drain_state_e state_q, state_d;
  logic start_rdy_q, req_val_q, resp_rdy_q, rec_val_q, done_val_q, busy_q;

  // Next-state selection; handshakes are judged against the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_val_i) state_d = ST_META_REQ; else state_d = ST_IDLE;
      ST_META_REQ:  if (drain_req_rdy_i) state_d = ST_META_RESP; else state_d = ST_META_REQ;
      ST_META_RESP: if (drain_resp_val_i) state_d = meta_zero_i ? ST_DONE : ST_ENT_REQ;
                    else state_d = ST_META_RESP;
      ST_ENT_REQ:   if (drain_req_rdy_i) state_d = ST_ENT_RESP; else state_d = ST_ENT_REQ;
      ST_ENT_RESP:  if (drain_resp_val_i) state_d = ST_REC_OUT; else state_d = ST_ENT_RESP;
      ST_REC_OUT:   if (rec_rdy_i) state_d = rec_last_i ? ST_DONE : ST_ENT_REQ;
                    else state_d = ST_REC_OUT;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign meta_cap_o    = (state_q == ST_META_RESP) && drain_resp_val_i;
  assign ent_cap_o     = (state_q == ST_ENT_RESP) && drain_resp_val_i;
  assign rec_adv_o     = (state_q == ST_REC_OUT) && rec_rdy_i;
  assign ld_meta_req_o = (state_q == ST_IDLE) && start_val_i;
  assign ld_ent_req_o  = (state_d == ST_ENT_REQ) && (state_q != ST_ENT_REQ);
  assign ld_done_o     = (state_d == ST_DONE) && (state_q != ST_DONE);

  // State register with output flags decoded from the next state so they leave on flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_rdy_q <= 1'b1;
      req_val_q   <= 1'b0;
      resp_rdy_q  <= 1'b0;
      rec_val_q   <= 1'b0;
      done_val_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_rdy_q <= (state_d == ST_IDLE);
      req_val_q   <= (state_d == ST_META_REQ) || (state_d == ST_ENT_REQ);
      resp_rdy_q  <= (state_d == ST_META_RESP) || (state_d == ST_ENT_RESP);
      rec_val_q   <= (state_d == ST_REC_OUT);
      done_val_q  <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign start_rdy_o      = start_rdy_q;
  assign drain_req_val_o  = req_val_q;
  assign drain_resp_rdy_o = resp_rdy_q;
  assign rec_val_o        = rec_val_q;
  assign done_val_o       = done_val_q;
  assign busy_o           = busy_q;

endmodule

// File: rtl/tracker_log_drain_datap.sv
// Drain datapath: walk counters, ring address arithmetic, request packing and response capture.
module tracker_log_drain_datap
  import tracker_pkg::*;
#(
  parameter int SRC_X              = 0,
  parameter int SRC_Y              = 0,
  parameter int DST_X              = 1,
  parameter int DST_Y              = 0,
  parameter int TRACKER_DEPTH_LOG2 = 4,
  parameter int REQ_NOC_W          = REQ_FLIT_W,
  parameter int RESP_NOC_W         = RESP_FLIT_W
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          meta_cap_i,
  input  logic                          ent_cap_i,
  input  logic                          rec_adv_i,
  input  logic                          ld_meta_req_i,
  input  logic                          ld_ent_req_i,
  input  logic                          ld_done_i,
  input  logic [RESP_NOC_W-1:0]         drain_resp_data_i,
  output logic                          meta_zero_o,
  output logic [REQ_NOC_W-1:0]          drain_req_data_o,
  output logic [TRACKER_STATS_W-1:0]    rec_data_o,
  output logic                          rec_last_o,
  output logic [TRACKER_DEPTH_LOG2:0]   done_count_o
);

  localparam int N = TRACKER_DEPTH_LOG2;

  resp_flit_t          resp_s;
  logic                unused_resp_s;
  logic [N:0]          meta_total_s;
  logic [N-1:0]        meta_base_s;
  logic [N-1:0]        ent_addr_s;
  logic [N:0]          idx_q, idx_d, total_q, total_d, cnt_q, cnt_d;
  logic [N-1:0]        base_q, base_d;
  req_flit_t           req_q, req_d;
  tracker_stats_struct rec_q, rec_d;
  logic                last_q, last_d;

  assign resp_s        = resp_flit_t'(drain_resp_data_i[RESP_FLIT_W-1:0]);
  assign unused_resp_s = ^{resp_s, drain_resp_data_i};

  // A wrapped log is full: oldest entry sits at wr_addr and all 2^N slots are live.
  assign meta_base_s  = resp_s.wrapped ? resp_s.wr_addr[N-1:0] : {N{1'b0}};
  assign meta_total_s = resp_s.wrapped ? {1'b1, {N{1'b0}}} : {1'b0, resp_s.wr_addr[N-1:0]};
  assign meta_zero_o  = (meta_total_s == {(N+1){1'b0}});

  // Next values of the walk state, captured record and outgoing request flit.
  always_comb begin
    idx_d      = idx_q;
    total_d    = total_q;
    base_d     = base_q;
    rec_d      = rec_q;
    last_d     = last_q;
    req_d      = req_q;
    cnt_d      = {(N+1){1'b0}};
    ent_addr_s = {N{1'b0}};
    if (meta_cap_i) begin
      idx_d   = {(N+1){1'b0}};
      total_d = meta_total_s;
      base_d  = meta_base_s;
    end else if (rec_adv_i) begin
      idx_d = idx_q + (N+1)'(1);
    end else begin
      idx_d = idx_q;
    end
    if (ent_cap_i) begin
      rec_d  = resp_s.stats;
      last_d = ((idx_q + (N+1)'(1)) == total_q);
    end else if (rec_adv_i) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end
    ent_addr_s = base_d + idx_d[N-1:0];
    if (ld_meta_req_i) begin
      req_d = make_req(DST_X, DST_Y, SRC_X, SRC_Y, REQ_META, {ADDR_W{1'b0}});
    end else if (ld_ent_req_i) begin
      req_d = make_req(DST_X, DST_Y, SRC_X, SRC_Y, REQ_ENTRY, ADDR_W'(ent_addr_s));
    end else begin
      req_d = req_q;
    end
    if (ld_done_i) cnt_d = total_d; else cnt_d = {(N+1){1'b0}};
  end

  // Datapath registers; everything returns to zero on reset, including a half-walked drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= {(N+1){1'b0}};
      total_q <= {(N+1){1'b0}};
      cnt_q   <= {(N+1){1'b0}};
      base_q  <= {N{1'b0}};
      req_q   <= {REQ_FLIT_W{1'b0}};
      rec_q   <= {TRACKER_STATS_W{1'b0}};
      last_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      req_q   <= req_d;
      rec_q   <= rec_d;
      last_q  <= last_d;
    end
  end

  assign drain_req_data_o = REQ_NOC_W'(req_q);
  assign rec_data_o       = rec_q;
  assign rec_last_o       = last_q;
  assign done_count_o     = cnt_q;

endmodule

// File: rtl/tracker_log_drain.sv
// Drains the tracker log over the NoC: metadata first, then every live entry oldest-first.
module tracker_log_drain
  import tracker_pkg::*;
#(
  parameter int SRC_X              = 0,
  parameter int SRC_Y              = 0,
  parameter int DST_X              = 1,
  parameter int DST_Y              = 0,
  parameter int TRACKER_DEPTH_LOG2 = 4,
  parameter int REQ_NOC_W          = REQ_FLIT_W,
  parameter int RESP_NOC_W         = RESP_FLIT_W
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_val,
  output logic                        start_rdy,
  output logic                        drain_req_val,
  output logic [REQ_NOC_W-1:0]        drain_req_data,
  input  logic                        drain_req_rdy,
  input  logic                        drain_resp_val,
  input  logic [RESP_NOC_W-1:0]       drain_resp_data,
  output logic                        drain_resp_rdy,
  output logic                        rec_val,
  output logic [TRACKER_STATS_W-1:0]  rec_data,
  output logic                        rec_last,
  input  logic                        rec_rdy,
  output logic                        done_val,
  output logic [TRACKER_DEPTH_LOG2:0] done_count,
  output logic                        busy
);

  logic meta_zero_s, meta_cap_s, ent_cap_s, rec_adv_s, ld_meta_req_s, ld_ent_req_s, ld_done_s;

  tracker_log_drain_ctrl u_ctrl (
    .clk              (clk),
    .rst              (rst),
    .start_val_i      (start_val),
    .start_rdy_o      (start_rdy),
    .drain_req_val_o  (drain_req_val),
    .drain_req_rdy_i  (drain_req_rdy),
    .drain_resp_val_i (drain_resp_val),
    .drain_resp_rdy_o (drain_resp_rdy),
    .rec_val_o        (rec_val),
    .rec_rdy_i        (rec_rdy),
    .done_val_o       (done_val),
    .busy_o           (busy),
    .meta_zero_i      (meta_zero_s),
    .rec_last_i       (rec_last),
    .meta_cap_o       (meta_cap_s),
    .ent_cap_o        (ent_cap_s),
    .rec_adv_o        (rec_adv_s),
    .ld_meta_req_o    (ld_meta_req_s),
    .ld_ent_req_o     (ld_ent_req_s),
    .ld_done_o        (ld_done_s)
  );

  tracker_log_drain_datap #(
    .SRC_X              (SRC_X),
    .SRC_Y              (SRC_Y),
    .DST_X              (DST_X),
    .DST_Y              (DST_Y),
    .TRACKER_DEPTH_LOG2 (TRACKER_DEPTH_LOG2),
    .REQ_NOC_W          (REQ_NOC_W),
    .RESP_NOC_W         (RESP_NOC_W)
  ) u_datap (
    .clk               (clk),
    .rst               (rst),
    .meta_cap_i        (meta_cap_s),
    .ent_cap_i         (ent_cap_s),
    .rec_adv_i         (rec_adv_s),
    .ld_meta_req_i     (ld_meta_req_s),
    .ld_ent_req_i      (ld_ent_req_s),
    .ld_done_i         (ld_done_s),
    .drain_resp_data_i (drain_resp_data),
    .meta_zero_o       (meta_zero_s),
    .drain_req_data_o  (drain_req_data),
    .rec_data_o        (rec_data),
    .rec_last_o        (rec_last),
    .done_count_o      (done_count)
  );

endmodule

// File: doc/tracker_log_drain.md
TRACKER_LOG_DRAIN -- requirements
Module: tracker_log_drain

Interface
REQ-001 Parameters SHALL be: SRC_X (-1, own NoC X coordinate); SRC_Y (-1, own NoC Y coordinate); DST_X (-1, tracker X coordinate); DST_Y (-1, tracker Y coordinate); TRACKER_DEPTH_LOG2 (-1, log2 of tracker log entries, N below); REQ_NOC_W (-1, request flit width); RESP_NOC_W (-1, response flit width).
REQ-002 clk  in  1  single clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start_val in 1 / start_rdy out 1  drain request handshake.
REQ-005 drain_req_val out 1 / drain_req_data out REQ_NOC_W / drain_req_rdy in 1  request flits to tracker.
REQ-006 drain_resp_val in 1 / drain_resp_data in RESP_NOC_W / drain_resp_rdy out 1  response flits from tracker.
REQ-007 rec_val out 1 / rec_data out TRACKER_STATS_W / rec_last out 1 / rec_rdy in 1  drained record stream.
REQ-008 done_val out 1 / done_count out N+1  one-cycle completion pulse carrying the number of records emitted.
REQ-009 busy  out  1  high in every state except IDLE.

Function
REQ-010 FSM states SHALL be IDLE, META_REQ, META_RESP, ENT_REQ, ENT_RESP, REC_OUT, DONE.
REQ-011 IDLE: start_rdy=1; on start_val&start_rdy -> META_REQ.
REQ-012 META_REQ: drain_req_val=1, flit type META, addr 0; on drain_req_rdy -> META_RESP.
REQ-013 META_RESP: drain_resp_rdy=1; on drain_resp_val, latch wr_addr (N bits) and wrapped (1 bit).
REQ-014 On metadata capture, base SHALL be wrapped ? wr_addr : 0 and total SHALL be wrapped ? 2^N : wr_addr, held in an N+1-bit counter.
REQ-015 If total==0 the FSM SHALL go to DONE; otherwise to ENT_REQ with idx=0.
REQ-016 ENT_REQ: drain_req_val=1, flit type ENTRY, addr=(base+idx) mod 2^N (N-bit truncation); on drain_req_rdy -> ENT_RESP.
REQ-017 ENT_RESP: drain_resp_rdy=1; on drain_resp_val, latch the record field into rec_data register -> REC_OUT.
REQ-018 REC_OUT: rec_val=1, rec_last=(idx==total-1); on rec_rdy, idx++, then -> DONE if last, else ENT_REQ.
REQ-019 DONE: done_val=1 for exactly one cycle with done_count=total -> IDLE.
REQ-020 At most one request SHALL be outstanding; drain_resp_rdy SHALL be 0 outside META_RESP/ENT_RESP.
REQ-021 All valid-driven outputs (drain_req_data, rec_data, rec_last) SHALL be stable while val is high and rdy is low.
REQ-022 start_val in non-IDLE states SHALL be ignored (start_rdy=0).
REQ-023 Request flit header SHALL carry dst (DST_X, DST_Y), src (SRC_X, SRC_Y), type, addr; response flit SHALL be single-flit.
REQ-024 Minimum per-record latency, with all rdys high and a 1-cycle tracker response, SHALL be 3 cycles (ENT_REQ, ENT_RESP, REC_OUT).

Reset
REQ-025 On rst assertion, at any time including mid-drain, the FSM SHALL go to IDLE asynchronously, clearing idx, total, base, wrapped, and rec_data.
REQ-026 Reset output values SHALL be: start_rdy=1, busy=0, and all other outputs 0; late responses arriving after reset SHALL be dropped (drain_resp_rdy=0 in IDLE).

Structure
REQ-027 tracker_pkg SHALL hold the request type enum (META, ENTRY), the request/response flit structs, and their widths; TRACKER_STATS_W and tracker_stats_struct SHALL be reused from it.
REQ-028 The block SHALL be split into tracker_log_drain_ctrl (FSM, handshakes) and tracker_log_drain_datap (counters, address arithmetic, flit pack/unpack).

Verification (N=4)
REQ-029 Metadata wr_addr=5, wrapped=0 -> addresses 0,1,2,3,4 requested; 5 records emitted; rec_last on the 5th; done_count=5.
REQ-030 Metadata wr_addr=11, wrapped=1 -> addresses 11..15,0..10 requested; 16 records emitted; done_count=16.
REQ-031 Metadata wr_addr=0, wrapped=0 -> no ENTRY requests, no rec_val; done_val pulses with done_count=0.
REQ-032 Random stalls on drain_req_rdy/rec_rdy and 0-7 cycle response delay -> data stable under stall; record order and contents match the model.
REQ-033 rst asserted during the 3rd REC_OUT -> outputs reach reset values immediately; a following start performs a full drain from META_REQ.
REQ-034 start_val pulsed during a drain -> ignored; exactly one done_val pulse per accepted start.
